// File: rtl/cache_controller.sv
// 2-way set-associative, write-through, no-write-allocate cache with one-word lines.
// It sits between the MEM stage and the SRAM controller. Read hits are served
// combinationally in the request cycle. Misses and every store go to the SRAM
// controller through its enable/ready handshake, and ready=0 freezes the pipeline.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | no SRAM traffic; serve read hits, launch misses and stores
//   RD_MISS | SRAM read in flight; on sram_ready bypass data and fill victim
//   WR_THRU | SRAM write in flight; on sram_ready update a hitting way
module cache_controller #(
  parameter int BASE_ADDR  = 1024,
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrEn,
  input  logic        rdEn,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ready,
  output logic        sram_wrEn,
  output logic        sram_rdEn,
  output logic [31:0] sram_address,
  output logic [31:0] sram_writeData,
  input  logic [31:0] sram_readData,
  input  logic        sram_ready
);

  localparam int WORD_BITS = INDEX_BITS + TAG_BITS;
  localparam int SETS      = 1 << INDEX_BITS;

  typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_t;

  state_t state, next_state;

  // Per-way storage. Valid and LRU bits need reset. Tag and data do not,
  // because they are only read when the matching valid bit is set.
  logic [SETS-1:0]      valid_q [2];
  logic [SETS-1:0]      lru_q;
  logic [TAG_BITS-1:0]  tag_mem [2][SETS];
  logic [31:0]          data_mem [2][SETS];

  logic [WORD_BITS-1:0]  word;
  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0]   tag;
  logic                  hit0, hit1, hit, hit_way, victim;
  logic [31:0]           hit_data;

  logic        ready_fsm;
  logic [31:0] rd_data_fsm;
  logic        fill_en, wr_upd_en, lru_we, lru_val, upd_way;

  // The base is word aligned, so subtracting it on the word bits alone gives the
  // same result as a full-width subtract. Out-of-range addresses alias by truncation.
  assign word  = address[WORD_BITS+1:2] - WORD_BITS'(BASE_ADDR >> 2);
  assign index = word[INDEX_BITS-1:0];
  assign tag   = word[WORD_BITS-1:INDEX_BITS];

  // Hit detection is evaluated every cycle on the held request address.
  always_comb begin
    hit0     = valid_q[0][index] && (tag_mem[0][index] == tag);
    hit1     = valid_q[1][index] && (tag_mem[1][index] == tag);
    hit      = hit0 | hit1;
    hit_way  = ~hit0;
    hit_data = hit0 ? data_mem[0][index] : data_mem[1][index];
    if (!valid_q[0][index])      victim = 1'b0;
    else if (!valid_q[1][index]) victim = 1'b1;
    else                         victim = lru_q[index];
  end

  assign sram_address   = address;
  assign sram_writeData = writeData;

  // While reset is asserted the pipeline must not be frozen and sees no data.
  assign ready    = rst ? ready_fsm : 1'b1;
  assign readData = rst ? rd_data_fsm : 32'd0;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state, handshake outputs, and cache update strobes.
  always_comb begin
    next_state  = state;
    ready_fsm   = 1'b1;
    rd_data_fsm = 32'd0;
    sram_rdEn   = 1'b0;
    sram_wrEn   = 1'b0;
    fill_en     = 1'b0;
    wr_upd_en   = 1'b0;
    lru_we      = 1'b0;
    lru_val     = 1'b0;
    upd_way     = 1'b0;
    case (state)
      IDLE: begin
        if (wrEn) begin
          ready_fsm  = 1'b0;
          next_state = WR_THRU;
        end else if (rdEn) begin
          if (hit) begin
            rd_data_fsm = hit_data;
            lru_we      = 1'b1;
            lru_val     = ~hit_way;
          end else begin
            ready_fsm  = 1'b0;
            next_state = RD_MISS;
          end
        end
      end
      RD_MISS: begin
        sram_rdEn = 1'b1;
        ready_fsm = sram_ready;
        if (sram_ready) begin
          rd_data_fsm = sram_readData;
          fill_en     = 1'b1;
          upd_way     = victim;
          lru_we      = 1'b1;
          lru_val     = ~victim;
          next_state  = IDLE;
        end
      end
      WR_THRU: begin
        sram_wrEn = 1'b1;
        ready_fsm = sram_ready;
        if (sram_ready) begin
          if (hit) begin
            wr_upd_en = 1'b1;
            upd_way   = hit_way;
            lru_we    = 1'b1;
            lru_val   = ~hit_way;
          end
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Valid and LRU bookkeeping; reset invalidates the whole cache.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q[0] <= '0;
      valid_q[1] <= '0;
      lru_q      <= '0;
    end else begin
      if (fill_en) valid_q[upd_way][index] <= 1'b1;
      if (lru_we)  lru_q[index] <= lru_val;
    end
  end

  // Tag/data arrays: a miss fill writes tag and data, a store hit writes data only.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[upd_way][index]  <= tag;
      data_mem[upd_way][index] <= sram_readData;
    end else if (wr_upd_en) begin
      data_mem[upd_way][index] <= writeData;
    end
  end

endmodule
